// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store port.
// Completes one word access after LATENCY cycles, stalling the pipeline with busy.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic [15:0] rdata,
    output logic        rvalid,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [16:0] DEPTH = 17'(2 ** DEPTH_LOG2);

    state_t                  state;
    logic [3:0]              cnt;
    logic                    op_wr_q;
    logic [DEPTH_LOG2-1:0]   addr_q;
    logic [15:0]             wdata_q;
    logic [15:0]             mem [0:(2**DEPTH_LOG2)-1];

    logic                    req;
    logic                    bad;
    logic                    accept;
    logic                    fire;
    logic                    fire_wr;
    logic [DEPTH_LOG2-1:0]   fire_addr;
    logic [15:0]             fire_data;

    always_comb begin
        req    = re ^ we;
        bad    = (re & we) | ((re | we) & ({1'b0, addr} >= DEPTH));
        accept = (state == IDLE) & req & ~bad;
        busy   = accept | (state == WAIT);
        // With LATENCY==1 the completion happens on the accepting edge, so the
        // live inputs stand in for the not-yet-captured request.
        fire   = ((state == WAIT) && (cnt == 4'd1)) || (accept && (LATENCY == 1));
        if (state == IDLE) begin
            fire_wr   = we;
            fire_addr = addr[DEPTH_LOG2-1:0];
            fire_data = wdata;
        end else begin
            fire_wr   = op_wr_q;
            fire_addr = addr_q;
            fire_data = wdata_q;
        end
    end

    // Storage is not reset; a reset on the completing edge discards the write.
    always_ff @(posedge clk) begin
        if (fire && fire_wr && !rst)
            mem[fire_addr] <= fire_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            rvalid  <= 1'b0;
            err     <= 1'b0;
        end else begin
            rvalid <= fire && !fire_wr;
            err    <= (state == IDLE) && bad;
            if (fire && !fire_wr)
                rdata <= mem[fire_addr];
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_wr_q <= we;
                        addr_q  <= addr[DEPTH_LOG2-1:0];
                        wdata_q <= wdata;
                        if (LATENCY == 1) begin
                            state <= DONE;
                        end else begin
                            cnt   <= 4'(LATENCY - 1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=4 instance plus a LATENCY=1 rebuild.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        re, we;
    logic [15:0] addr, wdata;
    logic        busy, rvalid, err;
    logic [15:0] rdata;

    logic        re1, we1;
    logic [15:0] addr1, wdata1;
    logic        busy1, rvalid1, err1;
    logic [15:0] rdata1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) dut (
        .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy), .rdata(rdata), .rvalid(rvalid), .err(err)
    );

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .re(re1), .we(we1), .addr(addr1), .wdata(wdata1),
        .busy(busy1), .rdata(rdata1), .rvalid(rvalid1), .err(err1)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
        end
    endtask

    // Drives one request at cycle 0, holds it through the DONE cycle, drops it after.
    task automatic txn(input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] exp_rd);
        @(posedge clk); #1;
        re = r; we = w; addr = a; wdata = d;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("busy c%0d", c), 16'(busy), 16'(c < 4));
            chk($sformatf("rvalid c%0d", c), 16'(rvalid), 16'((c == 4) && r));
            chk($sformatf("err c%0d", c), 16'(err), 16'h0);
            if (c == 4 && r) chk("rdata done", rdata, exp_rd);
        end
        @(posedge clk); #1;
        re = 1'b0; we = 1'b0;
        @(negedge clk);
        chk("busy after done", 16'(busy), 16'h0);
        chk("rvalid after done", 16'(rvalid), 16'h0);
    endtask

    task automatic bad_req(input logic r, input logic w, input logic [15:0] a, input string tag);
        @(posedge clk); #1;
        re = r; we = w; addr = a; wdata = 16'hDEAD;
        @(negedge clk);
        chk({tag, " busy"}, 16'(busy), 16'h0);
        chk({tag, " err c0"}, 16'(err), 16'h0);
        @(posedge clk); #1;
        re = 1'b0; we = 1'b0;
        @(negedge clk);
        chk({tag, " err c1"}, 16'(err), 16'h1);
        chk({tag, " rvalid c1"}, 16'(rvalid), 16'h0);
        for (int c = 2; c < 6; c++) begin
            @(negedge clk);
            chk({tag, " err late"}, 16'(err), 16'h0);
            chk({tag, " rvalid late"}, 16'(rvalid), 16'h0);
        end
    endtask

    initial begin
        rst = 1'b1;
        re = 0; we = 0; addr = 0; wdata = 0;
        re1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset rdata", rdata, 16'h0);
        chk("reset rvalid", 16'(rvalid), 16'h0);
        chk("reset err", 16'(err), 16'h0);
        chk("reset busy", 16'(busy), 16'h0);

        txn(1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0);
        txn(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("rdata hold", rdata, 16'hBEEF);
        end

        txn(1'b0, 1'b1, 16'h0001, 16'h1111, 16'h0);
        bad_req(1'b1, 1'b1, 16'h0001, "re_we");
        bad_req(1'b1, 1'b0, 16'h0400, "oor");
        bad_req(1'b0, 1'b1, 16'hFFFF, "oor_wr");
        chk("rdata after errs", rdata, 16'hBEEF);
        txn(1'b1, 1'b0, 16'h0001, 16'h0000, 16'h1111);

        txn(1'b0, 1'b1, 16'h03FF, 16'hC3A5, 16'h0);
        txn(1'b1, 1'b0, 16'h03FF, 16'h0000, 16'hC3A5);
        txn(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
        txn(1'b0, 1'b1, 16'h0010, 16'h7E57, 16'h0);
        txn(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h7E57);

        // Async reset in the middle of a write must discard it.
        txn(1'b0, 1'b1, 16'h0020, 16'h5555, 16'h0);
        @(posedge clk); #1;
        we = 1'b1; addr = 16'h0020; wdata = 16'h1234;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1; we = 1'b0;
        #1;
        chk("rst busy", 16'(busy), 16'h0);
        chk("rst rdata", rdata, 16'h0);
        chk("rst rvalid", 16'(rvalid), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post rst rvalid", 16'(rvalid), 16'h0);
            chk("post rst busy", 16'(busy), 16'h0);
        end
        txn(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h5555);

        // LATENCY=1: write at cycle 0, DONE at 1, read accepted at 2, DONE at 3.
        @(posedge clk); #1;
        we1 = 1'b1; addr1 = 16'h0003; wdata1 = 16'h00AA;
        @(negedge clk);
        chk("l1 wr busy c0", 16'(busy1), 16'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("l1 wr busy c1", 16'(busy1), 16'h0);
        chk("l1 wr rvalid c1", 16'(rvalid1), 16'h0);
        @(posedge clk); #1;
        we1 = 1'b0; re1 = 1'b1;
        @(negedge clk);
        chk("l1 rd busy c2", 16'(busy1), 16'h1);
        chk("l1 rd rvalid c2", 16'(rvalid1), 16'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("l1 rd busy c3", 16'(busy1), 16'h0);
        chk("l1 rd rvalid c3", 16'(rvalid1), 16'h1);
        chk("l1 rd rdata c3", rdata1, 16'h00AA);
        @(posedge clk); #1;
        re1 = 1'b0;
        @(negedge clk);
        chk("l1 rvalid c4", 16'(rvalid1), 16'h0);
        chk("l1 rdata hold", rdata1, 16'h00AA);
        chk("l1 err", 16'(err1), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
